// File: rtl/bus_sequencer.sv
// Bus sequencer: copies an 8-entry EPROM image into SRAM over a shared 4-bit bus, then reads it back to the display.
// Define VERIFY_EN to add a ROM-vs-RAM compare pass per address that drives a sticky error flag.
module bus_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] data_in,
    output logic [2:0] addr,
    output logic       rom_cs,
    output logic       rom_oe,
    output logic       ram_cs,
    output logic       ram_we,
    output logic       ram_oe,
    output logic       sw_ben,
    output logic       busy,
    output logic       done,
    output logic [3:0] display
`ifdef VERIFY_EN
    ,
    output logic       error
`endif
);

`ifdef VERIFY_EN
    typedef enum logic [2:0] {IDLE, COPY, READ, DONE, ROM_RD, RAM_RD} state_t;
`else
    typedef enum logic [1:0] {IDLE, COPY, READ, DONE} state_t;
`endif

    typedef struct packed {
        logic rom_cs;
        logic rom_oe;
        logic ram_cs;
        logic ram_we;
        logic ram_oe;
        logic sw_ben;
        logic busy;
        logic done;
    } ctl_t;

    state_t state;
    state_t nxt;
    ctl_t   ctl;

`ifdef VERIFY_EN
    logic [3:0] expected;
`endif

    // DONE keeps the switch buffer on so the bus is always driven by exactly one source.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            IDLE: c.sw_ben = 1'b1;
            COPY: begin
                c.rom_cs = 1'b1;
                c.rom_oe = 1'b1;
                c.ram_cs = 1'b1;
                c.ram_we = 1'b1;
                c.busy   = 1'b1;
            end
            READ: begin
                c.ram_cs = 1'b1;
                c.ram_oe = 1'b1;
                c.busy   = 1'b1;
            end
            DONE: begin
                c.sw_ben = 1'b1;
                c.busy   = 1'b1;
                c.done   = 1'b1;
            end
`ifdef VERIFY_EN
            ROM_RD: begin
                c.rom_cs = 1'b1;
                c.rom_oe = 1'b1;
                c.busy   = 1'b1;
            end
            RAM_RD: begin
                c.ram_cs = 1'b1;
                c.ram_oe = 1'b1;
                c.busy   = 1'b1;
            end
`endif
            default: c.sw_ben = 1'b1;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = COPY;
            COPY: if (addr == 3'd7) begin
`ifdef VERIFY_EN
                nxt = ROM_RD;
`else
                nxt = READ;
`endif
            end
            READ: if (addr == 3'd7) nxt = DONE;
`ifdef VERIFY_EN
            ROM_RD: nxt = RAM_RD;
            RAM_RD: nxt = (addr == 3'd7) ? DONE : ROM_RD;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Controls are registered from the next state so every enable is glitch-free and still a pure state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ctl     <= decode(IDLE);
            addr    <= '0;
            display <= '0;
`ifdef VERIFY_EN
            expected <= '0;
            error    <= 1'b0;
`endif
        end else begin
            state <= nxt;
            ctl   <= decode(nxt);
            case (state)
                IDLE: begin
                    display <= data_in;
                    addr    <= '0;
`ifdef VERIFY_EN
                    if (start) error <= 1'b0;
`endif
                end
                COPY: addr <= addr + 3'd1;
                READ: begin
                    display <= data_in;
                    addr    <= addr + 3'd1;
                end
`ifdef VERIFY_EN
                ROM_RD: expected <= data_in;
                RAM_RD: begin
                    display <= data_in;
                    addr    <= addr + 3'd1;
                    if (data_in != expected) error <= 1'b1;
                end
`endif
                default: addr <= '0;
            endcase
        end
    end

    assign rom_cs = ctl.rom_cs;
    assign rom_oe = ctl.rom_oe;
    assign ram_cs = ctl.ram_cs;
    assign ram_we = ctl.ram_we;
    assign ram_oe = ctl.ram_oe;
    assign sw_ben = ctl.sw_ben;
    assign busy   = ctl.busy;
    assign done   = ctl.done;

    a_one_driver: assert property (@(posedge clk) disable iff (reset)
        $onehot({rom_cs & rom_oe, ram_cs & ram_oe, sw_ben}));
    a_we_oe: assert property (@(posedge clk) disable iff (reset) !(ram_we && ram_oe));

endmodule
